// File: rtl/signal_conflict_pkg.sv
// rtl/signal_conflict_pkg.sv - light codes, fault codes and monitor states shared by the conflict monitor
// Contents: light_t and its code constants, fault_code_t, mon_state_t, is_active() helper.
package signal_conflict_pkg;

    typedef logic [1:0] light_t;

    localparam light_t GREEN     = 2'b00;
    localparam light_t ILLEGAL   = 2'b01;
    localparam light_t RED       = 2'b10;
    localparam light_t FLASH_YEL = 2'b11;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_CONFLICT = 2'd1,
        FC_ILLEGAL  = 2'd2,
        FC_WATCHDOG = 2'd3
    } fault_code_t;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_PENDING = 2'd1,
        ST_FAULTED = 2'd2
    } mon_state_t;

    // Anything that is not red lets traffic move (illegal codes count as active too).
    function automatic logic is_active(input light_t code);
        return code != RED;
    endfunction

endpackage

// File: rtl/light_change_watchdog.sv
// rtl/light_change_watchdog.sv - idle timer that flags when no light input has changed for too long
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   i_lights      all 8 light codes packed into 16 bits
//   i_clear       restart the idle count (monitor leaving FAULTED)
//   o_timeout     registered flag; high on the edge after which the idle count has reached WDOG_CYCLES-1,
//                 so the monitor acts on it at the edge where the count reaches WDOG_CYCLES
module light_change_watchdog
    import signal_conflict_pkg::*;
#(
    parameter int WDOG_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] i_lights,
    input  logic        i_clear,
    output logic        o_timeout
);

    logic [15:0] r_snapshot;
    logic [15:0] r_idle;
    logic        r_timeout;
    logic        w_changed;
    logic [15:0] w_idle_next;

    assign w_changed = (i_lights != r_snapshot);

    always_comb begin
        w_idle_next = r_idle;
        if (i_clear || w_changed) begin
            w_idle_next = 16'd0;
        end else if (r_idle != 16'hFFFF) begin
            w_idle_next = r_idle + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snapshot <= {8{RED}};
            r_idle     <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_snapshot <= i_lights;
            r_idle     <= w_idle_next;
            // Registered one edge early so the monitor faults exactly when the count hits the limit.
            r_timeout  <= !i_clear && (w_idle_next >= 16'(WDOG_CYCLES - 1));
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/signal_conflict_monitor.sv
// rtl/signal_conflict_monitor.sv - intersection conflict monitor that latches faults and demands all-red
// Optional feature macro: CONFLICT_MON_WDOG_EN (light-change watchdog, fault_code 3).
// Ports:
//   clk, reset_n                         clock and asynchronous active-low reset
//   light_north/south/east/west [1:0]    through-lane light codes
//   left_north/south/east/west  [1:0]    left-turn light codes
//   clear_fault                          operator clear
//   fault, force_red                     latched fault indication / all-red demand
//   fault_code [1:0]                     0 none, 1 conflict, 2 illegal code, 3 watchdog
//   fault_count [7:0]                    entries into FAULTED, saturating at 255
module signal_conflict_monitor
    import signal_conflict_pkg::*;
#(
    parameter int FILTER_CYCLES = 2,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  light_t     light_north,
    input  light_t     light_south,
    input  light_t     light_east,
    input  light_t     light_west,
    input  light_t     left_north,
    input  light_t     left_south,
    input  light_t     left_east,
    input  light_t     left_west,
    input  logic       clear_fault,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       force_red,
    output logic [7:0] fault_count
);

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15 || WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_bad_params
        $error("signal_conflict_monitor: FILTER_CYCLES or WDOG_CYCLES out of range");
    end

    mon_state_t  r_state;
    fault_code_t r_fault_code;
    logic        r_fault;
    logic [3:0]  r_filter_cnt;
    logic [7:0]  r_fault_count;

    logic        w_ns_active;
    logic        w_ew_active;
    logic        w_raw_conflict;
    logic        w_raw_illegal;
    logic        w_raw_fault;
    logic        w_filter_done;
    logic        w_exit;
    logic        w_wd_timeout;
    fault_code_t w_cause;

    assign w_ns_active = is_active(light_north) | is_active(light_south)
                       | is_active(left_north)  | is_active(left_south);
    assign w_ew_active = is_active(light_east)  | is_active(light_west)
                       | is_active(left_east)   | is_active(left_west);

    // A green left turn clashes with the green through movement coming the other way.
    assign w_raw_conflict = (w_ns_active && w_ew_active)
                          || (left_north == GREEN && light_south == GREEN)
                          || (left_south == GREEN && light_north == GREEN)
                          || (left_east  == GREEN && light_west  == GREEN)
                          || (left_west  == GREEN && light_east  == GREEN);

    assign w_raw_illegal = (light_north == ILLEGAL) || (light_south == ILLEGAL)
                        || (light_east  == ILLEGAL) || (light_west  == ILLEGAL)
                        || (left_north  == ILLEGAL) || (left_south  == ILLEGAL)
                        || (left_east   == ILLEGAL) || (left_west   == ILLEGAL);

    assign w_raw_fault = w_raw_illegal || w_raw_conflict;
    assign w_cause     = w_raw_illegal ? FC_ILLEGAL : FC_CONFLICT;

    // The filter count is 0 in MONITOR, so one comparison covers both the
    // FILTER_CYCLES==1 shortcut and completion of the filter in PENDING.
    assign w_filter_done = w_raw_fault && ((r_filter_cnt + 4'd1) >= 4'(FILTER_CYCLES));
    assign w_exit        = (r_state == ST_FAULTED) && clear_fault && !w_raw_fault;

`ifdef CONFLICT_MON_WDOG_EN
    light_change_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_lights  ({left_west, left_east, left_south, left_north,
                     light_west, light_east, light_south, light_north}),
        .i_clear   (w_exit),
        .o_timeout (w_wd_timeout)
    );
`else
    assign w_wd_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_MONITOR;
            r_fault       <= 1'b0;
            r_fault_code  <= FC_NONE;
            r_filter_cnt  <= 4'd0;
            r_fault_count <= 8'd0;
        end else begin
            case (r_state)
                ST_MONITOR, ST_PENDING: begin
                    if (w_filter_done || w_wd_timeout) begin
                        // A completed filter outranks the watchdog on the same edge.
                        r_state      <= ST_FAULTED;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_filter_done ? w_cause : FC_WATCHDOG;
                        r_filter_cnt <= 4'd0;
                        if (r_fault_count != 8'hFF) begin
                            r_fault_count <= r_fault_count + 8'd1;
                        end
                    end else if (w_raw_fault) begin
                        r_state      <= ST_PENDING;
                        r_filter_cnt <= r_filter_cnt + 4'd1;
                    end else begin
                        r_state      <= ST_MONITOR;
                        r_filter_cnt <= 4'd0;
                    end
                end
                ST_FAULTED: begin
                    if (w_exit) begin
                        r_state      <= ST_MONITOR;
                        r_fault      <= 1'b0;
                        r_fault_code <= FC_NONE;
                    end
                end
                default: begin
                    r_state      <= ST_MONITOR;
                    r_fault      <= 1'b0;
                    r_fault_code <= FC_NONE;
                    r_filter_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign fault       = r_fault;
    assign force_red   = r_fault;
    assign fault_code  = r_fault_code;
    assign fault_count = r_fault_count;

endmodule
